// File: rtl/pkt_gen_if.sv
// Handshake and configuration bundle between a burst requester and pkt_gen.
// The master side requests bursts and supplies the frame shape; the slave
// side (the generator) drives the frame line and burst status back.
interface pkt_gen_if #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_pkts;
    logic [LEN_W-1:0] low_len;
    logic [LEN_W-1:0] gap_len;
    logic             sig;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_cnt;

    modport master (
        output start,
        output abort,
        output num_pkts,
        output low_len,
        output gap_len,
        input  sig,
        input  busy,
        input  done,
        input  sent_cnt
    );

    modport slave (
        input  start,
        input  abort,
        input  num_pkts,
        input  low_len,
        input  gap_len,
        output sig,
        output busy,
        output done,
        output sent_cnt
    );
endinterface

// File: rtl/pkt_gen.sv
// Programmable active-low frame generator for the falling-edge frame-counting
// link. Emits a burst of frames with programmable low width and high gap and
// keeps a running count of falling edges sent.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sig high, not busy; waits for start (abort wins over start)
// LOW   | sig low for the latched low width of the current frame
// GAP   | sig high for the latched gap; then next frame or burst end
module pkt_gen #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pkt_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] num_q,      num_d;
    logic [LEN_W-1:0] low_q,      low_d;
    logic [LEN_W-1:0] gap_q,      gap_d;
    logic [LEN_W-1:0] len_cnt_q,  len_cnt_d;
    logic [CNT_W-1:0] frm_cnt_q,  frm_cnt_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic             sig_q,      sig_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [LEN_W-1:0] low_clamp;
    logic [LEN_W-1:0] gap_clamp;
    logic             len_tc;
    logic             last_frame;

    // Zero lengths behave as one cycle; terminal-count and completion decode.
    // Completion uses the internal frame counter, never sent_cnt, and a
    // latched count of zero means run until aborted.
    always_comb begin
        low_clamp  = (bus.low_len == '0) ? LEN_W'(1) : bus.low_len;
        gap_clamp  = (bus.gap_len == '0) ? LEN_W'(1) : bus.gap_len;
        len_tc     = (len_cnt_q == '0);
        last_frame = (frm_cnt_q == num_q) && (num_q != '0);
    end

    // State and datapath register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            low_q      <= '0;
            gap_q      <= '0;
            len_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            sent_cnt_q <= '0;
            sig_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            low_q      <= low_d;
            gap_q      <= gap_d;
            len_cnt_q  <= len_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            sig_q      <= sig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and registered-output decode; done is a one-cycle pulse.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        low_d      = low_q;
        gap_d      = gap_q;
        len_cnt_d  = len_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        sent_cnt_d = sent_cnt_q;
        sig_d      = sig_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sig_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.start && !bus.abort) begin
                    state_d    = ST_LOW;
                    num_d      = bus.num_pkts;
                    low_d      = low_clamp;
                    gap_d      = gap_clamp;
                    len_cnt_d  = low_clamp - LEN_W'(1);
                    frm_cnt_d  = CNT_W'(1);
                    sent_cnt_d = CNT_W'(1);
                    sig_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_LOW: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    sig_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (len_tc) begin
                    state_d   = ST_GAP;
                    sig_d     = 1'b1;
                    len_cnt_d = gap_q - LEN_W'(1);
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end

            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    sig_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (len_tc) begin
                    if (last_frame) begin
                        state_d = ST_IDLE;
                        sig_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Frame and edge counters wrap silently in continuous mode.
                        state_d    = ST_LOW;
                        sig_d      = 1'b0;
                        len_cnt_d  = low_q - LEN_W'(1);
                        frm_cnt_d  = frm_cnt_q + CNT_W'(1);
                        sent_cnt_d = sent_cnt_q + CNT_W'(1);
                    end
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All outputs come straight from flops.
    always_comb begin
        bus.sig      = sig_q;
        bus.busy     = busy_q;
        bus.done     = done_q;
        bus.sent_cnt = sent_cnt_q;
    end

endmodule

// File: tb/tb_pkt_gen.sv
// Self-checking bench for pkt_gen: a table of burst scenarios, randomized
// bursts with parameter scrambling mid-burst, and hand-written corner cases.
// Expected waveforms come from a closed-form frame timing model.
module tb_pkt_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pkt_gen_if #(.CNT_W(32), .LEN_W(16)) bus ();

    pkt_gen #(.CNT_W(32), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit     sig;
        bit     busy;
        bit     done;
        longint sent;
    } exp_t;

    typedef struct {
        int     n;
        int     l;
        int     g;
        int     a;          // abort driven after edge T+a; 0 = no abort
        bit     scramble;
        longint exp_done_t;
        longint exp_sent;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output values after edge T+t for a burst accepted at edge T.
    function automatic exp_t model(input int n, input int l, input int g, input int a, input longint t);
        exp_t   r;
        longint lc, gc, p;
        lc = (l == 0) ? 1 : l;
        gc = (g == 0) ? 1 : g;
        p  = lc + gc;
        if (a > 0 && t > a) begin
            r.sig  = 1'b1;
            r.busy = 1'b0;
            r.done = (t == a + 1);
            r.sent = (a - 1) / p + 1;
        end else if (n != 0 && t >= 1 + n * p) begin
            r.sig  = 1'b1;
            r.busy = 1'b0;
            r.done = (t == 1 + n * p);
            r.sent = n;
        end else begin
            r.sig  = (((t - 1) % p) >= lc);
            r.busy = 1'b1;
            r.done = 1'b0;
            r.sent = (t - 1) / p + 1;
        end
        return r;
    endfunction

    function automatic longint end_time(input int n, input int l, input int g, input int a);
        longint p;
        p = ((l == 0) ? 1 : l) + ((g == 0) ? 1 : g);
        if (a > 0) return a + 1;
        return 1 + n * p;
    endfunction

    // Start a burst from IDLE and compare every cycle until the done cycle.
    task automatic run_burst(input string tag, input int n, input int l, input int g,
                             input int a, input bit scramble,
                             output longint done_t, output longint sent_at_done);
        exp_t   e;
        longint t_end;
        bit     seen;
        t_end        = end_time(n, l, g, a);
        seen         = 1'b0;
        done_t       = -1;
        sent_at_done = -1;
        bus.num_pkts = n;
        bus.low_len  = 16'(l);
        bus.gap_len  = 16'(g);
        bus.abort    = 1'b0;
        bus.start    = 1'b1;
        for (longint t = 1; t <= t_end; t++) begin
            tick();
            e = model(n, l, g, a, t);
            check({tag, ".sig"},  64'(bus.sig),      64'(e.sig));
            check({tag, ".busy"}, 64'(bus.busy),     64'(e.busy));
            check({tag, ".done"}, 64'(bus.done),     64'(e.done));
            check({tag, ".sent"}, 64'(bus.sent_cnt), 64'(e.sent));
            if (bus.done === 1'b1 && !seen) begin
                seen         = 1'b1;
                done_t       = t;
                sent_at_done = longint'(bus.sent_cnt);
            end
            bus.start = 1'b0;
            bus.abort = (t == a);
            if (scramble && t < t_end && t != a) begin
                bus.num_pkts = $urandom;
                bus.low_len  = 16'($urandom);
                bus.gap_len  = 16'($urandom);
                bus.start    = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check({tag, ".done_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".idle_sig"},  64'(bus.sig),  64'(1));
        check({tag, ".idle_busy"}, 64'(bus.busy), 64'(0));
        check({tag, ".idle_done"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[7];
        longint dt, st;
        int     n, l, g, a;
        longint p, e_end;

        vecs[0] = '{1, 2, 3, 0,  1'b0, 6,  1};
        vecs[1] = '{3, 4, 4, 0,  1'b1, 25, 3};
        vecs[2] = '{2, 0, 0, 0,  1'b0, 5,  2};
        vecs[3] = '{0, 2, 2, 17, 1'b0, 18, 5};
        vecs[4] = '{4, 1, 1, 0,  1'b1, 9,  4};
        vecs[5] = '{2, 5, 1, 3,  1'b0, 4,  1};
        vecs[6] = '{5, 1, 3, 9,  1'b1, 10, 3};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.num_pkts = '0;
        bus.low_len  = '0;
        bus.gap_len  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sig",  64'(bus.sig),      64'(1));
        check("rst.busy", 64'(bus.busy),     64'(0));
        check("rst.done", 64'(bus.done),     64'(0));
        check("rst.sent", 64'(bus.sent_cnt), 64'(0));
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");

        // Odd entries chain straight into the next burst on the done cycle.
        for (int i = 0; i < 7; i++) begin
            run_burst($sformatf("v%0d", i), vecs[i].n, vecs[i].l, vecs[i].g,
                      vecs[i].a, vecs[i].scramble, dt, st);
            check($sformatf("v%0d.done_t", i), 64'(dt), 64'(vecs[i].exp_done_t));
            check($sformatf("v%0d.sent_end", i), 64'(st), 64'(vecs[i].exp_sent));
            if (i % 2 == 0) begin
                tick();
                check_idle($sformatf("v%0d", i));
            end
        end

        // start+abort together in IDLE, then abort alone: nothing happens.
        bus.num_pkts = 3;
        bus.low_len  = 2;
        bus.gap_len  = 2;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        tick();
        check_idle("st_ab");
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("ab_idle%0d", i));
        end
        bus.abort = 1'b0;
        tick();
        check_idle("ab_rel");

        // Reset asserted mid-cycle during LOW of a 10-frame burst.
        bus.num_pkts = 10;
        bus.low_len  = 3;
        bus.gap_len  = 3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("mid.sig_low", 64'(bus.sig), 64'(0));
        check("mid.busy",    64'(bus.busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.sig",  64'(bus.sig),      64'(1));
        check("arst.busy", 64'(bus.busy),     64'(0));
        check("arst.sent", 64'(bus.sent_cnt), 64'(0));
        check("arst.done", 64'(bus.done),     64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("arst_hold%0d", i));
        end
        #3;
        rst_n = 1'b1;
        tick();
        check_idle("arst_rel");
        run_burst("post_arst", 1, 2, 3, 0, 1'b0, dt, st);
        check("post_arst.done_t",   64'(dt), 64'(6));
        check("post_arst.sent_end", 64'(st), 64'(1));
        tick();
        check_idle("post_arst");

        // Randomized bursts with scrambled inputs mid-burst and random aborts.
        for (int r = 0; r < 10; r++) begin
            n     = $urandom_range(1, 4);
            l     = $urandom_range(0, 4);
            g     = $urandom_range(0, 4);
            p     = ((l == 0) ? 1 : l) + ((g == 0) ? 1 : g);
            e_end = 1 + n * p;
            a     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32'(e_end - 1))) : 0;
            run_burst($sformatf("r%0d", r), n, l, g, a, 1'b1, dt, st);
            check($sformatf("r%0d.done_t", r), 64'(dt), 64'((a > 0) ? a + 1 : e_end));
            check($sformatf("r%0d.sent_end", r), 64'(st), 64'((a > 0) ? (a - 1) / p + 1 : n));
            tick();
            check_idle($sformatf("r%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_gen.md
# pkt_gen

Programmable packet/frame pulse generator: the transmit end of the falling-edge frame-counting link. On a start request it emits a programmed number of active-low frames on `sig`, each with programmable low width and high gap, and keeps a running count of frames sent. The downstream frame counter samples this `sig` and should read back the same total. The block is used for link bring-up, loopback self-test and rate characterisation.

## Interface
- `CNT_W`, default 32: width of the frame-count request and the sent counter.
- `LEN_W`, default 16: width of the low-width and gap-length fields.

- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a burst. Sampled only in IDLE.
- `abort`, in, 1: terminate the burst in progress.
- `num_pkts`, in, CNT_W: frames per burst. 0 means continuous operation until abort.
- `low_len`, in, LEN_W: cycles `sig` is held low per frame. 0 is treated as 1.
- `gap_len`, in, LEN_W: cycles `sig` is held high after each frame. 0 is treated as 1.
- `sig`, out, 1: generated frame line. Idle level is high.
- `busy`, out, 1: high while a burst is in progress.
- `done`, out, 1: one-cycle pulse at burst end, for either completion or abort.
- `sent_cnt`, out, CNT_W: number of falling edges emitted since the last accepted start.

## Operation
- States:
  - IDLE: `sig`=1, `busy`=0.
  - LOW: `sig`=0.
  - GAP: `sig`=1.
- All outputs are registered.
- Reset values: state IDLE, `sig`=1, `busy`=0, `done`=0, `sent_cnt`=0. All internal counters are 0.
- IDLE to LOW: occurs when `start`=1 and `abort`=0.
  - `num_pkts`, `low_len` and `gap_len` are latched; clamp zero lengths to 1.
  - `sent_cnt` is set to 1 (cleared, then the first edge is counted).
- LOW to GAP: after the latched low count expires.
- GAP exits after the latched gap count expires:
  - If frames sent equals latched `num_pkts` and `num_pkts`≠0: go to IDLE and assert `done`.
  - Otherwise: go to LOW and increment `sent_cnt`.
- `sent_cnt` increments exactly once per high-to-low transition of `sig`. It wraps modulo 2^CNT_W. In continuous mode, wrap is silent and the generator keeps running.
- Completion compares an internal frame counter (CNT_W bits) with the latched `num_pkts`. It does not use `sent_cnt`.
- `abort`=1 while `busy` (LOW or GAP): the next edge gives `sig`=1, state IDLE, `busy`=0, `done`=1.
  - `sent_cnt` is held and includes any truncated frame.
  - `abort` in IDLE is ignored and produces no `done`.
- `abort` has priority over `start` when both are high in IDLE.
- `start` while `busy` is ignored. Input changes during a burst have no effect because parameters are latched.
- `done` is high for exactly one cycle. It is never asserted together with `busy`=1.
- Asserting `rst_n` low at any time immediately forces the reset values, including `sig`=1, asynchronously. No `done` is produced.

## Timing
- Let T be the edge at which `start` is accepted. Let L and G be the clamped lengths and N the latched `num_pkts`.
- At edge T+1: `busy`=1, `sig`=0, `sent_cnt`=1.
- Frame k (k=1..N):
  - `sig` falls at edge T+1+(k-1)(L+G).
  - `sig` rises L cycles later.
  - The frame period is L+G cycles.
- Burst end: edge T+1+N(L+G) gives `busy`=0 and `done`=1. `done` clears on the following edge.
- The earliest new start is accepted at the same edge that `done` is high (state is IDLE). The next burst's first low then follows one cycle later.
- Abort sampled at edge A: `sig`=1, `busy`=0 and `done`=1 take effect at A+1.
- The receiver needs at least 2 cycles in each level. Minimum legal L=1 and G=1 are generated faithfully. The receiver margin is a system-level concern.

## Test plan
- Reset, then N=1, L=2, G=3:
  - `sig` is low at T+1..T+2 and high from T+3.
  - `done` pulses at T+6.
  - `sent_cnt`=1.
- N=3, L=4, G=4:
  - Three falling edges at T+1, T+9 and T+17.
  - `done` at T+25.
  - `sent_cnt`=3.
  - `busy` is high from T+1 to T+24.
- L=0, G=0, N=2: lengths clamp to 1.
  - `sig` pattern from T+1 is 0,1,0,1.
  - `done` at T+5.
  - `sent_cnt`=2.
- Continuous mode, N=0, L=2, G=2, abort asserted during the 5th LOW:
  - `sig` is 1 on the next edge.
  - `done` pulses once.
  - `sent_cnt`=5.
  - `busy`=0.
- Start pulsed mid-burst, and start+abort together in IDLE:
  - Both are ignored.
  - Frame count and timing are unchanged.
  - No `done` in IDLE.
- `rst_n` asserted during LOW of a N=10 burst:
  - `sig`=1, `busy`=0 and `sent_cnt`=0 asynchronously.
  - No `done`.
  - A fresh start after release behaves as in the first scenario.
